// File: rtl/cpu_pkg.sv
// Shared selector definitions: mode encodings and channel-index width helper.
// No logic; constants and a pure function only.
// Imported by the selector and arbiter blocks.
package cpu_pkg;

    localparam logic MUX_MODE_DIRECT = 1'b0;
    localparam logic MUX_MODE_RR     = 1'b1;

    // Width of an index able to name n channels; never below one bit.
    function automatic int chan_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester strictly after ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own accept condition.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = chan_idx_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Scan farthest-to-nearest so the candidate closest after ptr wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            logic [SELW-1:0] cand;
            cand = SELW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxn_pipe.sv
// N-input registered selector, directed or round-robin, with valid/ready and flush.
// Latency: one cycle from input transfer to out_valid; full throughput when out_ready=1.
// Backpressure: in_ready drops while the output is held (out_valid & ~out_ready) or flushing.
module muxn_pipe
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = chan_idx_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] ch_data [N];
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [SELW-1:0]  g;
    logic             grant_vld;
    logic             can_acc;
    logic             xfer;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign can_acc = ~flush & (~out_valid | out_ready);

    // Directed mode always grants, so in_ready can lead in_valid on that channel.
    always_comb begin
        g         = '0;
        grant_vld = 1'b0;
        if (mode == MUX_MODE_RR) begin
            g         = rr_idx;
            grant_vld = rr_any;
        end else begin
            grant_vld = 1'b1;
            if (int'(sel) < N) begin
                g = sel;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && grant_vld && can_acc) begin
            in_ready[g] = 1'b1;
        end
    end

    assign xfer = in_valid[g] & in_ready[g];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[g];
            out_ch    <= g;
            if (mode == MUX_MODE_RR) begin
                rr_ptr <= g;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
